// File: rtl/truth_table_scanner_pkg.sv
// Shared types and helpers for the truth-table scanner and its settle timer.
package truth_table_pkg;

  localparam int MAX_INPUTS = 6;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_e;

  function automatic int table_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Reloadable down-counter; expire is high once the count has drained to zero.
module settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                cnt_d = load_val;
    else if (cnt_q != '0)    cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks every input pattern of an N-input function, samples its output after a
// settle time, and compares the assembled truth table against a reference.
module truth_table_scanner
  import truth_table_pkg::*;
#(
  parameter  int N_INPUTS      = 3,
  parameter  int SETTLE_CYCLES = 4,
  localparam int TABLE_W       = table_width(N_INPUTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TABLE_W-1:0]  expected,
  output logic [N_INPUTS-1:0] stim,
  input  logic                resp,
  output logic                busy,
  output logic                done,
  output logic [TABLE_W-1:0]  table_out,
  output logic                table_valid,
  output logic                match
);

  // One extra index bit keeps the terminal compare from wrapping.
  localparam int IDX_W = N_INPUTS + 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_W - 1);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TABLE_W-1:0] table_q, table_d;
  logic [TABLE_W-1:0] exp_q, exp_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               match_q, match_d;
  logic               tmr_load, tmr_expire;

  settle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (RELOAD),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    table_d  = table_q;
    exp_d    = exp_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    match_d  = match_q;
    tmr_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          idx_d    = '0;
          table_d  = '0;
          exp_d    = expected;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          match_d  = 1'b0;
          tmr_load = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_expire) begin
          table_d[idx_q[N_INPUTS-1:0]] = resp;
          if (idx_q == LAST_IDX) begin
            // match is taken from the table including this final sample.
            state_d = DONE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            match_d = (table_d == exp_q);
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            tmr_load = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      table_q <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      match_q <= match_d;
    end
  end

  assign stim        = idx_q[N_INPUTS-1:0];
  assign busy        = busy_q;
  assign done        = (state_q == DONE);
  assign table_out   = table_q;
  assign table_valid = valid_q;
  assign match       = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: three scanners (settle 4, 1, 3) driven by small function models.
module tb_truth_table_scanner;

  typedef struct {
    logic [7:0] tbl;
    logic       m;
    int         lat;
    int         bsy;
    int         acc;
  } exp_t;

  logic             clk = 1'b0;
  logic [2:0]       rst, start, busy, done, tv, match;
  logic [2:0][7:0]  expv, tout;
  logic [2:0][2:0]  stim;
  logic [1:0]       mode [3];
  logic [7:0]       tt = 8'hE3;
  int               cyc = 0;
  int               n_chk = 0;
  int               n_fail = 0;
  exp_t             sbq [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", nm, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 4 : ((g == 1) ? 1 : 3);
    logic       r;
    logic [2:0] d1, d2;
    int         bcnt;

    // mode 0: f(x) from tt, mode 1: constant 1, mode 2: f(x) seen two cycles late
    always @(posedge clk) begin
      d1 <= stim[g];
      d2 <= d1;
    end
    assign r = (mode[g] == 2'd1) ? 1'b1 : (mode[g] == 2'd2) ? tt[d2] : tt[stim[g]];

    truth_table_scanner #(.N_INPUTS(3), .SETTLE_CYCLES(S)) u_dut (
      .clk         (clk),
      .rst         (rst[g]),
      .start       (start[g]),
      .expected    (expv[g]),
      .stim        (stim[g]),
      .resp        (r),
      .busy        (busy[g]),
      .done        (done[g]),
      .table_out   (tout[g]),
      .table_valid (tv[g]),
      .match       (match[g])
    );

    always @(negedge clk) begin
      exp_t e;
      if (rst[g]) bcnt = 0;
      else begin
        if (busy[g]) bcnt++;
        if (done[g]) begin
          chk("done_expected", g, 32'(sbq[g].size() > 0), 1);
          if (sbq[g].size() > 0) begin
            e = sbq[g].pop_front();
            chk("table_out", g, 32'(tout[g]), 32'(e.tbl));
            chk("match", g, 32'(match[g]), 32'(e.m));
            chk("table_valid", g, 32'(tv[g]), 1);
            chk("latency", g, 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("busy_cycles", g, 32'(bcnt), 32'(e.bsy));
          end
          bcnt = 0;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input int g, input logic [7:0] e, output int acc);
    start[g] = 1'b1;
    expv[g]  = e;
    tick();
    start[g] = 1'b0;
    acc      = cyc;
  endtask

  task automatic push(input int g, input logic [7:0] t, input logic m, input int lat, input int bsy, input int acc);
    exp_t e;
    e.tbl = t; e.m = m; e.lat = lat; e.bsy = bsy; e.acc = acc;
    sbq[g].push_back(e);
  endtask

  task automatic wait_idle(input int g);
    int k = 0;
    while ((busy[g] || done[g]) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("idle_timeout", g, 32'(busy[g] | done[g]), 0);
    tick(2);
  endtask

  initial begin
    int acc;
    rst   = '1;
    start = '0;
    expv  = '0;
    mode[0] = 2'd0; mode[1] = 2'd1; mode[2] = 2'd2;
    tick(2);
    for (int g = 0; g < 3; g++) begin
      chk("rst_stim", g, 32'(stim[g]), 0);
      chk("rst_busy", g, 32'(busy[g]), 0);
      chk("rst_done", g, 32'(done[g]), 0);
      chk("rst_table", g, 32'(tout[g]), 0);
      chk("rst_valid", g, 32'(tv[g]), 0);
      chk("rst_match", g, 32'(match[g]), 0);
    end
    rst = '0;
    tick(3);

    // Function E3, matching reference
    launch(0, 8'hE3, acc);
    push(0, 8'hE3, 1'b1, 33, 32, acc);
    chk("busy_after_start", 0, 32'(busy[0]), 1);
    chk("valid_after_start", 0, 32'(tv[0]), 0);
    chk("stim_first", 0, 32'(stim[0]), 0);
    wait_idle(0);
    chk("valid_held", 0, 32'(tv[0]), 1);
    chk("table_held", 0, 32'(tout[0]), 32'h E3);

    // Same function, wrong reference
    launch(0, 8'hC7, acc);
    push(0, 8'hE3, 1'b0, 33, 32, acc);
    wait_idle(0);
    chk("valid_held_mismatch", 0, 32'(tv[0]), 1);
    chk("match_held_mismatch", 0, 32'(match[0]), 0);

    // Reset in cycle 10 of a scan: two patterns already sampled
    launch(0, 8'hE3, acc);
    tick(9);
    chk("pre_rst_table", 0, 32'(tout[0]), 32'h03);
    chk("pre_rst_stim", 0, 32'(stim[0]), 2);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("post_rst_busy", 0, 32'(busy[0]), 0);
    chk("post_rst_stim", 0, 32'(stim[0]), 0);
    chk("post_rst_table", 0, 32'(tout[0]), 0);
    chk("post_rst_valid", 0, 32'(tv[0]), 0);
    tick(3);
    launch(0, 8'hE3, acc);
    push(0, 8'hE3, 1'b1, 33, 32, acc);
    chk("rescan_stim", 0, 32'(stim[0]), 0);
    wait_idle(0);

    // start held high: one done, re-accept in the IDLE cycle after DONE
    start[0] = 1'b1;
    expv[0]  = 8'hE3;
    tick();
    acc = cyc;
    push(0, 8'hE3, 1'b1, 33, 32, acc);
    tick(33);
    chk("idle_after_done_valid", 0, 32'(tv[0]), 1);
    chk("idle_after_done_busy", 0, 32'(busy[0]), 0);
    tick();
    chk("reaccept_valid_drop", 0, 32'(tv[0]), 0);
    chk("reaccept_busy", 0, 32'(busy[0]), 1);
    push(0, 8'hE3, 1'b1, 33, 32, cyc);
    start[0] = 1'b0;
    wait_idle(0);

    // Constant-1 model, settle 1: one pattern per cycle
    launch(1, 8'hFF, acc);
    push(1, 8'hFF, 1'b1, 9, 8, acc);
    for (int k = 0; k < 8; k++) begin
      chk("stim_step", 1, 32'(stim[1]), 32'(k));
      tick();
    end
    wait_idle(1);

    // Two-cycle-late model: settle 1 reads stale outputs, settle 3 is correct
    mode[1] = 2'd2;
    tick(3);
    launch(1, 8'hE3, acc);
    push(1, 8'h8F, 1'b0, 9, 8, acc);
    wait_idle(1);
    launch(2, 8'hE3, acc);
    push(2, 8'hE3, 1'b1, 25, 24, acc);
    wait_idle(2);

    tick(2);
    for (int g = 0; g < 3; g++) chk("scoreboard_drained", g, 32'(sbq[g].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
